myproject_mul_pipe_hs: RTL and testbench

//  Parametrised, pipelined successor to the combinational HLS multiplier.

---
 rtl/myproject_mul_pkg.sv | 21 ++
 rtl/myproject_mul_pipe_hs_if.sv | 26 ++
 rtl/myproject_mul_core.sv | 51 +++++
 rtl/myproject_mul_pipe_hs.sv | 107 ++++++++++
 tb/tb_myproject_mul_pipe_hs.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/myproject_mul_pkg.sv
// rtl/myproject_mul_pkg.sv - shared constants and output-range helpers for the pipelined multiplier
package myproject_mul_pkg;

    localparam int SAT_WRAP = 0;
    localparam int SAT_SAT  = 1;

    function automatic logic signed [63:0] out_min(input int width, input bit is_signed);
        if (is_signed) return -(64'sd1 <<< (width - 1));
        return 64'sd0;
    endfunction

    function automatic logic signed [63:0] out_max(input int width, input bit is_signed);
        if (is_signed) return (64'sd1 <<< (width - 1)) - 64'sd1;
        return (64'sd1 <<< width) - 64'sd1;
    endfunction

    function automatic logic fit_check(input logic signed [63:0] r, input int width, input bit is_signed);
        return (r >= out_min(width, is_signed)) && (r <= out_max(width, is_signed));
    endfunction

endpackage

// File: rtl/myproject_mul_pipe_hs_if.sv
// rtl/myproject_mul_pipe_hs_if.sv - operand/result handshake bundle for the pipelined multiplier
interface myproject_mul_pipe_hs_if #(
    parameter int DIN0_WIDTH = 12,
    parameter int DIN1_WIDTH = 9,
    parameter int DOUT_WIDTH = 21
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  ovf;
    logic                  clr_ovf;

    modport master (
        output in_valid, din0, din1, out_ready, clr_ovf,
        input  in_ready, out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready, clr_ovf,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/myproject_mul_core.sv
// rtl/myproject_mul_core.sv - combinational extend, multiply, shift and wrap/saturate
module myproject_mul_core
    import myproject_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 12,
    parameter int DIN1_WIDTH  = 9,
    parameter int DOUT_WIDTH  = 21,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int SHIFT       = 0,
    parameter int SAT_MODE    = 0
) (
    input  logic [DIN0_WIDTH-1:0] i_din0,
    input  logic [DIN1_WIDTH-1:0] i_din1,
    output logic [DOUT_WIDTH-1:0] o_res,
    output logic                  o_oor
);
    // One spare bit over the operand widths holds any signed/unsigned product mix exactly
    localparam int P          = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam bit OUT_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    logic                w_ext0;
    logic                w_ext1;
    logic signed [P-1:0] w_op0;
    logic signed [P-1:0] w_op1;
    logic signed [P-1:0] w_prod;
    logic signed [P-1:0] w_shr;
    logic signed [63:0]  w_r;
    logic signed [63:0]  w_min;
    logic signed [63:0]  w_max;
    logic signed [63:0]  w_sel;

    always_comb begin
        w_ext0 = (DIN0_SIGNED != 0) && i_din0[DIN0_WIDTH-1];
        w_ext1 = (DIN1_SIGNED != 0) && i_din1[DIN1_WIDTH-1];
        w_op0  = {{(P-DIN0_WIDTH){w_ext0}}, i_din0};
        w_op1  = {{(P-DIN1_WIDTH){w_ext1}}, i_din1};
        w_prod = w_op0 * w_op1;
        w_shr  = w_prod >>> SHIFT;
        w_r    = 64'(w_shr);
        w_min  = out_min(DOUT_WIDTH, OUT_SIGNED);
        w_max  = out_max(DOUT_WIDTH, OUT_SIGNED);
        o_oor  = !fit_check(w_r, DOUT_WIDTH, OUT_SIGNED);
        w_sel  = w_r;
        if (o_oor && (SAT_MODE == SAT_SAT)) begin
            w_sel = (w_r < w_min) ? w_min : w_max;
        end
        o_res  = DOUT_WIDTH'(w_sel);
    end

endmodule

// File: rtl/myproject_mul_pipe_hs.sv
// rtl/myproject_mul_pipe_hs.sv - pipelined multiplier with valid/ready handshake and sticky overflow
module myproject_mul_pipe_hs
    import myproject_mul_pkg::*;
#(
    parameter int DIN0_WIDTH  = 12,
    parameter int DIN1_WIDTH  = 9,
    parameter int DOUT_WIDTH  = 21,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int NUM_STAGE   = 2,
    parameter int SHIFT       = 0,
    parameter int SAT_MODE    = SAT_WRAP
) (
    input logic                    ap_clk,
    input logic                    ap_rst_n,
    myproject_mul_pipe_hs_if.slave bus
);
    logic                  w_adv;
    logic                  w_core_v;
    logic [DIN0_WIDTH-1:0] w_core_d0;
    logic [DIN1_WIDTH-1:0] w_core_d1;
    logic [DOUT_WIDTH-1:0] w_res;
    logic                  w_oor;

    logic                  r_out_valid;
    logic [DOUT_WIDTH-1:0] r_dout;
    logic                  r_ovf;

    // The whole pipe moves as one; a stalled output freezes every stage
    assign w_adv         = bus.out_ready | ~r_out_valid;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.ovf       = r_ovf;

    generate
        if (NUM_STAGE == 1) begin : g_comb_in
            assign w_core_v  = bus.in_valid;
            assign w_core_d0 = bus.din0;
            assign w_core_d1 = bus.din1;
        end else begin : g_op_pipe
            // Operands ride the retiming stages so the multiplier can be pulled back through them
            localparam int NOP = NUM_STAGE - 1;
            logic                  r_v  [NOP];
            logic [DIN0_WIDTH-1:0] r_d0 [NOP];
            logic [DIN1_WIDTH-1:0] r_d1 [NOP];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int i = 0; i < NOP; i++) begin
                        r_v[i]  <= 1'b0;
                        r_d0[i] <= '0;
                        r_d1[i] <= '0;
                    end
                end else if (w_adv) begin
                    r_v[0]  <= bus.in_valid;
                    r_d0[0] <= bus.din0;
                    r_d1[0] <= bus.din1;
                    for (int i = 1; i < NOP; i++) begin
                        r_v[i]  <= r_v[i-1];
                        r_d0[i] <= r_d0[i-1];
                        r_d1[i] <= r_d1[i-1];
                    end
                end
            end

            assign w_core_v  = r_v[NOP-1];
            assign w_core_d0 = r_d0[NOP-1];
            assign w_core_d1 = r_d1[NOP-1];
        end
    endgenerate

    myproject_mul_core #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH),
        .DIN0_SIGNED(DIN0_SIGNED),
        .DIN1_SIGNED(DIN1_SIGNED),
        .SHIFT      (SHIFT),
        .SAT_MODE   (SAT_MODE)
    ) u_core (
        .i_din0(w_core_d0),
        .i_din1(w_core_d1),
        .o_res (w_res),
        .o_oor (w_oor)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_adv) begin
                r_out_valid <= w_core_v;
                r_dout      <= w_res;
            end
            // A set in the same cycle as a clear wins
            if (w_adv && w_core_v && w_oor) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_myproject_mul_pipe_hs.sv
// tb/tb_myproject_mul_pipe_hs.sv - self-checking bench for the pipelined handshake multiplier
module tb_myproject_mul_pipe_hs;

    localparam int NI = 7;
    localparam int P_D   [NI] = '{21, 16, 16, 21, 21, 16, 18};
    localparam int P_S0  [NI] = '{ 0,  0,  0,  0,  1,  0,  1};
    localparam int P_S1  [NI] = '{ 1,  1,  1,  1,  1,  0,  0};
    localparam int P_SH  [NI] = '{ 0,  0,  0,  4,  0,  2,  1};
    localparam int P_SAT [NI] = '{ 0,  1,  0,  0,  0,  1,  1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_in_valid = 1'b0;
    logic [11:0] t_din0 = '0;
    logic [8:0]  t_din1 = '0;
    logic        t_out_ready = 1'b1;
    logic        t_clr = 1'b0;

    always #5 clk = ~clk;

    myproject_mul_pipe_hs_if #(.DIN0_WIDTH(12), .DIN1_WIDTH(9), .DOUT_WIDTH(21)) if0 ();
    myproject_mul_pipe_hs_if #(.DIN0_WIDTH(12), .DIN1_WIDTH(9), .DOUT_WIDTH(16)) if1 ();
    myproject_mul_pipe_hs_if #(.DIN0_WIDTH(12), .DIN1_WIDTH(9), .DOUT_WIDTH(16)) if2 ();
    myproject_mul_pipe_hs_if #(.DIN0_WIDTH(12), .DIN1_WIDTH(9), .DOUT_WIDTH(21)) if3 ();
    myproject_mul_pipe_hs_if #(.DIN0_WIDTH(12), .DIN1_WIDTH(9), .DOUT_WIDTH(21)) if4 ();
    myproject_mul_pipe_hs_if #(.DIN0_WIDTH(12), .DIN1_WIDTH(9), .DOUT_WIDTH(16)) if5 ();
    myproject_mul_pipe_hs_if #(.DIN0_WIDTH(12), .DIN1_WIDTH(9), .DOUT_WIDTH(18)) if6 ();

    assign if0.in_valid = t_in_valid; assign if0.din0 = t_din0; assign if0.din1 = t_din1; assign if0.out_ready = t_out_ready; assign if0.clr_ovf = t_clr;
    assign if1.in_valid = t_in_valid; assign if1.din0 = t_din0; assign if1.din1 = t_din1; assign if1.out_ready = t_out_ready; assign if1.clr_ovf = t_clr;
    assign if2.in_valid = t_in_valid; assign if2.din0 = t_din0; assign if2.din1 = t_din1; assign if2.out_ready = t_out_ready; assign if2.clr_ovf = t_clr;
    assign if3.in_valid = t_in_valid; assign if3.din0 = t_din0; assign if3.din1 = t_din1; assign if3.out_ready = t_out_ready; assign if3.clr_ovf = t_clr;
    assign if4.in_valid = t_in_valid; assign if4.din0 = t_din0; assign if4.din1 = t_din1; assign if4.out_ready = t_out_ready; assign if4.clr_ovf = t_clr;
    assign if5.in_valid = t_in_valid; assign if5.din0 = t_din0; assign if5.din1 = t_din1; assign if5.out_ready = t_out_ready; assign if5.clr_ovf = t_clr;
    assign if6.in_valid = t_in_valid; assign if6.din0 = t_din0; assign if6.din1 = t_din1; assign if6.out_ready = t_out_ready; assign if6.clr_ovf = t_clr;

    myproject_mul_pipe_hs #(.DOUT_WIDTH(21)) u0 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if0));
    myproject_mul_pipe_hs #(.DOUT_WIDTH(16), .SAT_MODE(1)) u1 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if1));
    myproject_mul_pipe_hs #(.DOUT_WIDTH(16), .SAT_MODE(0)) u2 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if2));
    myproject_mul_pipe_hs #(.DOUT_WIDTH(21), .SHIFT(4)) u3 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if3));
    myproject_mul_pipe_hs #(.DOUT_WIDTH(21), .DIN0_SIGNED(1)) u4 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if4));
    myproject_mul_pipe_hs #(.DOUT_WIDTH(16), .DIN0_SIGNED(0), .DIN1_SIGNED(0), .NUM_STAGE(1), .SHIFT(2), .SAT_MODE(1))
        u5 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if5));
    myproject_mul_pipe_hs #(.DOUT_WIDTH(18), .DIN0_SIGNED(1), .DIN1_SIGNED(0), .NUM_STAGE(4), .SHIFT(1), .SAT_MODE(1))
        u6 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if6));

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint msk(input longint v, input int d);
        return v & ((longint'(1) << d) - 1);
    endfunction

    // Reference: exact integer product, floor shift, then range fit and wrap/saturate
    function automatic longint model(input logic [11:0] a, input logic [8:0] b, input int id, output bit oor);
        longint x, y, r, lo, hi;
        x = (P_S0[id] != 0) ? longint'($signed(a)) : longint'(a);
        y = (P_S1[id] != 0) ? longint'($signed(b)) : longint'(b);
        r = (x * y) >>> P_SH[id];
        if ((P_S0[id] | P_S1[id]) != 0) begin
            lo = -(longint'(1) << (P_D[id] - 1));
            hi = (longint'(1) << (P_D[id] - 1)) - 1;
        end else begin
            lo = 0;
            hi = (longint'(1) << P_D[id]) - 1;
        end
        oor = (r < lo) || (r > hi);
        if (oor && P_SAT[id] != 0) r = (r < lo) ? lo : hi;
        return r;
    endfunction

    typedef struct { longint val; bit oor; } tok_t;
    tok_t q [NI][$];
    bit   sticky [NI];
    int   n_emit [NI];
    bit   mon_ovf_en = 1'b0;

    task automatic mon_step(input int id, input bit acc, input bit emit, input longint dout, input bit ovf);
        tok_t t;
        if (!rst_n) begin
            q[id].delete();
            sticky[id] = 1'b0;
            return;
        end
        if (emit) begin
            n_emit[id]++;
            if (q[id].size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_out[%0d]: actual=%0d expected=no token", id, dout);
            end else begin
                t = q[id].pop_front();
                chk($sformatf("stream_dout[%0d]", id), dout, msk(t.val, P_D[id]));
                if (mon_ovf_en) chk($sformatf("stream_ovf[%0d]", id), longint'(ovf), longint'(sticky[id] | t.oor));
                sticky[id] = sticky[id] | t.oor;
            end
        end
        if (acc) begin
            t.val = model(t_din0, t_din1, id, t.oor);
            q[id].push_back(t);
        end
    endtask

    always @(negedge clk) mon_step(0, if0.in_valid && if0.in_ready, if0.out_valid && if0.out_ready, longint'(if0.dout), if0.ovf);
    always @(negedge clk) mon_step(1, if1.in_valid && if1.in_ready, if1.out_valid && if1.out_ready, longint'(if1.dout), if1.ovf);
    always @(negedge clk) mon_step(2, if2.in_valid && if2.in_ready, if2.out_valid && if2.out_ready, longint'(if2.dout), if2.ovf);
    always @(negedge clk) mon_step(3, if3.in_valid && if3.in_ready, if3.out_valid && if3.out_ready, longint'(if3.dout), if3.ovf);
    always @(negedge clk) mon_step(4, if4.in_valid && if4.in_ready, if4.out_valid && if4.out_ready, longint'(if4.dout), if4.ovf);
    always @(negedge clk) mon_step(5, if5.in_valid && if5.in_ready, if5.out_valid && if5.out_ready, longint'(if5.dout), if5.ovf);
    always @(negedge clk) mon_step(6, if6.in_valid && if6.in_ready, if6.out_valid && if6.out_ready, longint'(if6.dout), if6.ovf);

    typedef struct {
        logic [11:0] a;
        logic [8:0]  b;
        int          e0, e1, e2, e3, e4;
        bit          oor16;
    } vec_t;

    vec_t   vt [9];
    longint prev_dout;
    bit     have_prev;
    bit     acc;
    int     k, base, cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // e0: default, e1: 16b sat, e2: 16b wrap, e3: shift 4, e4: din0 signed
        vt[0] = '{12'd4095, 9'h100, -1048320, -32768,   256, -65520,    256, 1'b1};
        vt[1] = '{12'd4095, 9'd255,  1044225,  32767, -4351,  65264,   -255, 1'b1};
        vt[2] = '{12'd4095, 9'd3,      12285,  12285, 12285,    767,     -3, 1'b0};
        vt[3] = '{12'd0,    9'h100,        0,      0,     0,      0,      0, 1'b0};
        vt[4] = '{12'd1,    9'h1FF,       -1,     -1,    -1,     -1,     -1, 1'b0};
        vt[5] = '{12'd7,    9'h1FF,       -7,     -7,    -7,     -1,     -7, 1'b0};
        vt[6] = '{12'd2048, 9'd16,     32768,  32767, -32768,  2048, -32768, 1'b1};
        vt[7] = '{12'd2048, 9'h1F0,   -32768, -32768, -32768, -2048,  32768, 1'b0};
        vt[8] = '{12'd4095, 9'h1FF,    -4095,  -4095, -4095,   -256,      1, 1'b0};

        do_reset();
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_dout", if0.dout, 0);
        chk("rst_dout_known", longint'($isunknown(if0.dout)), 0);
        chk("rst_ovf", if0.ovf, 0);
        chk("rst_in_ready", if0.in_ready, 1);
        chk("rst_out_valid_ns4", if6.out_valid, 0);

        for (int i = 0; i < 9; i++) begin
            t_clr = 1'b1;
            tick();
            t_clr = 1'b0;
            chk($sformatf("v%0d_ovf_cleared", i), if1.ovf, 0);
            t_in_valid = 1'b1;
            t_din0 = vt[i].a;
            t_din1 = vt[i].b;
            tick();
            t_in_valid = 1'b0;
            chk($sformatf("v%0d_lat_early", i), if0.out_valid, 0);
            chk($sformatf("v%0d_lat_ns1", i), if5.out_valid, 1);
            tick();
            chk($sformatf("v%0d_lat", i), if0.out_valid, 1);
            chk($sformatf("v%0d_dout_def", i), if0.dout, msk(vt[i].e0, 21));
            chk($sformatf("v%0d_dout_sat16", i), if1.dout, msk(vt[i].e1, 16));
            chk($sformatf("v%0d_dout_wrap16", i), if2.dout, msk(vt[i].e2, 16));
            chk($sformatf("v%0d_dout_shift4", i), if3.dout, msk(vt[i].e3, 21));
            chk($sformatf("v%0d_dout_s0", i), if4.dout, msk(vt[i].e4, 21));
            chk($sformatf("v%0d_ovf_sat16", i), if1.ovf, vt[i].oor16);
            chk($sformatf("v%0d_ovf_wrap16", i), if2.ovf, vt[i].oor16);
            chk($sformatf("v%0d_ovf_def", i), if0.ovf, 0);
            tick();
            tick();
            chk($sformatf("v%0d_lat_ns4", i), if6.out_valid, 1);
        end

        // Overflowing token enters the final stage in the same cycle clr_ovf is high
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        t_in_valid = 1'b1;
        t_din0 = 12'd4095;
        t_din1 = 9'd255;
        tick();
        t_in_valid = 1'b0;
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        chk("ovf_set_beats_clr", if1.ovf, 1);
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        chk("ovf_clr", if1.ovf, 0);

        // Back-to-back stream with a 3-cycle output stall
        repeat (4) tick();
        base = n_emit[0];
        k = 0;
        have_prev = 1'b0;
        t_din0 = 12'($urandom);
        t_din1 = 9'($urandom);
        for (int cyc = 0; cyc < 60 && k < 8; cyc++) begin
            t_in_valid = 1'b1;
            t_out_ready = !(cyc >= 4 && cyc < 7);
            @(negedge clk);
            if (!t_out_ready && if0.out_valid) begin
                chk("stall_in_ready", if0.in_ready, 0);
                if (have_prev) chk("stall_dout_hold", if0.dout, prev_dout);
                prev_dout = longint'(if0.dout);
                have_prev = 1'b1;
            end
            acc = if0.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                t_din0 = 12'($urandom);
                t_din1 = 9'($urandom);
            end
        end
        chk("stream_accepted", k, 8);
        chk("stall_seen", have_prev, 1);
        t_in_valid = 1'b0;
        t_out_ready = 1'b1;
        repeat (6) tick();
        chk("stream_emitted", n_emit[0] - base, 8);

        // Asynchronous reset with two tokens in flight
        t_in_valid = 1'b1;
        t_din0 = 12'd4095;
        t_din1 = 9'd255;
        tick();
        t_din0 = 12'd5;
        t_din1 = 9'd5;
        tick();
        t_in_valid = 1'b0;
        chk("inflight_valid", if0.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", if0.out_valid, 0);
        chk("arst_dout", if0.dout, 0);
        chk("arst_ovf", if1.ovf, 0);
        chk("arst_out_valid_ns4", if6.out_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(if0.out_valid) + int'(if6.out_valid);
            @(posedge clk);
            #1;
        end
        chk("no_stale_after_reset", cnt, 0);

        // Random traffic against the reference model, overflow tracking enabled
        do_reset();
        mon_ovf_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            t_in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       begin t_din0 = 12'hFFF; t_din1 = 9'h100; end
                1:       begin t_din0 = 12'h800; t_din1 = 9'h0FF; end
                default: begin t_din0 = 12'($urandom); t_din1 = 9'($urandom); end
            endcase
            t_out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        t_in_valid = 1'b0;
        t_out_ready = 1'b1;
        repeat (8) tick();
        for (int id = 0; id < NI; id++) begin
            chk($sformatf("drain_empty[%0d]", id), q[id].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
